// File: rtl/req_gnt_arbiter.sv
// Round-robin request/grant arbiter with bounded tenure. A grant is held until the
// owner drops req or pulses done, or is forcibly released after MAX_HOLD cycles.
module req_gnt_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int OW      = (N > 1) ? $clog2(N) : 1,
  localparam int CW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          timeout,
  output logic          state_o
);

  // Handshake: req is level-sensitive; gnt asserts one cycle after req is seen and
  // stays until the owner drops req, pulses done, or the hold limit is reached.
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] pick;

  // Search starts just after the last owner so the last owner has lowest priority.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] last);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && r[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    pick      = rr_pick(req, owner_q);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          gnt_d   = ONE_N << pick;
          owner_d = pick;
          cnt_d   = '0;
        end else begin
          gnt_d = '0;
        end
      end
      S_GRANT: begin
        if (!req[owner_q] || done[owner_q]) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      owner_q   <= OW'(N - 1);
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed bench for req_gnt_arbiter (N=4, MAX_HOLD=8): inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_req_gnt_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;
  logic       state_o;

  int n_chk;
  int n_err;

  req_gnt_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout),
    .state_o (state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, "_busy"}, 32'(busy), 32'(|exp_gnt));
    check({tag, "_to"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_to"}, 32'(timeout), 32'h0);
    check({tag, "_owner"}, 32'(owner), 32'h3);
    check({tag, "_state"}, 32'(state_o), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    n_chk = 0;
    n_err = 0;
    rstn  = 1'b1;
    req   = 4'b0000;
    done  = 4'b0000;

    #1 rstn = 1'b0;
    #2;
    check_reset_state("rst0");
    tick();
    tick();
    check_grant("rst_idle", 4'b0000, 1'b0);
    rstn = 1'b1;
    tick();
    check_grant("idle_noreq", 4'b0000, 1'b0);

    // single requester, held three edges then dropped
    req = 4'b0001;
    tick();
    check_grant("r1_c0", 4'b0001, 1'b0);
    check("r1_owner", 32'(owner), 32'h0);
    check("r1_state", 32'(state_o), 32'h1);
    tick();
    check_grant("r1_c1", 4'b0001, 1'b0);
    tick();
    check_grant("r1_c2", 4'b0001, 1'b0);
    req = 4'b0000;
    tick();
    check_grant("r1_rel", 4'b0000, 1'b0);
    check("r1_owner_hold", 32'(owner), 32'h0);
    tick();
    check_grant("r1_idle", 4'b0000, 1'b0);

    // all requesting, no done: 0,1,2,3,0 with forced release each 8 cycles
    rstn = 1'b0;
    #1;
    check_reset_state("rst1");
    rstn = 1'b1;
    req  = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << (t % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        check_grant($sformatf("rr%0d_c%0d", t, c), exp_g, 1'b0);
      end
      check("rr_owner", 32'(owner), 32'(t % 4));
      tick();
      check_grant($sformatf("rr%0d_tmo", t), 4'b0000, 1'b1);
    end
    req = 4'b0000;
    tick();
    check_grant("rr_end", 4'b0000, 1'b0);

    // owner 1 releases via done on its fourth cycle, then 2 is served
    req = 4'b0110;
    tick();
    check_grant("d1_c0", 4'b0010, 1'b0);
    check("d1_owner", 32'(owner), 32'h1);
    tick();
    tick();
    tick();
    check_grant("d1_c3", 4'b0010, 1'b0);
    done = 4'b0010;
    tick();
    check_grant("d1_rel", 4'b0000, 1'b0);
    done = 4'b0000;
    tick();
    check_grant("d2_c0", 4'b0100, 1'b0);
    check("d2_owner", 32'(owner), 32'h2);

    // non-owner done and non-owner requests do not disturb the grant
    done = 4'b1001;
    req  = 4'b0111;
    tick();
    check_grant("nod_c1", 4'b0100, 1'b0);
    done = 4'b0000;
    tick();
    check_grant("nod_c2", 4'b0100, 1'b0);
    req = 4'b0000;
    tick();
    check_grant("nod_rel", 4'b0000, 1'b0);

    // done while idle is ignored
    done = 4'b1111;
    tick();
    check_grant("idle_done", 4'b0000, 1'b0);
    done = 4'b0000;

    // done coinciding with the hold limit is a normal release
    req = 4'b1000;
    tick();
    check_grant("lim_c0", 4'b1000, 1'b0);
    for (int c = 1; c < 8; c++) begin
      tick();
      check_grant($sformatf("lim_c%0d", c), 4'b1000, 1'b0);
    end
    done = 4'b1000;
    tick();
    check_grant("lim_rel", 4'b0000, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    tick();
    check_grant("lim_idle", 4'b0000, 1'b0);

    // reset mid-tenure with owner 3 drops gnt without a clock
    req = 4'b1000;
    tick();
    check_grant("ar_c0", 4'b1000, 1'b0);
    check("ar_owner", 32'(owner), 32'h3);
    tick();
    rstn = 1'b0;
    #1;
    check_reset_state("ar_rst");
    #1;
    rstn = 1'b1;
    req  = 4'b1001;
    tick();
    check_grant("ar_first", 4'b0001, 1'b0);
    check("ar_first_owner", 32'(owner), 32'h0);
    req = 4'b0000;
    tick();
    check_grant("ar_rel", 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
